// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants for the seven-segment display scheduler
// Segment patterns are abcdefg, active-low; the decimal point is appended by the decoder.
package ssd_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic {
    GAME = 1'b0,
    MSG  = 1'b1
  } sched_state_e;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [7:0] BLANK = 8'hFF;

endpackage

// File: rtl/ssd_hex_decoder.sv
// rtl/ssd_hex_decoder.sv - hex nibble plus decimal point to active-low cathodes
// Output order is {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] cathodes_o
);

  logic [6:0] seg;

  always_comb begin
    seg = SEG_8;
    case (nibble_i)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_8;
    endcase
  end

  assign cathodes_o = {seg, ~dp_i};

endmodule

// File: rtl/ssd_display_scheduler.sv
// rtl/ssd_display_scheduler.sv - 8-digit scan scheduler arbitrating game page vs held message page
// Define SSD_SCHED_BLINK_EN to blink the message page every BLINK_FRAMES frames.
module ssd_display_scheduler
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV    = 262144,
  parameter int HOLD_FRAMES = 190
`ifdef SSD_SCHED_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 16
`endif
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic [31:0] game_data,
  input  logic [7:0]  game_mask,
  input  logic [7:0]  game_dp,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  input  logic [7:0]  msg_mask,
  input  logic        msg_cancel,
  output logic [7:0]  An,
  output logic [7:0]  Cathodes,
  output logic        page,
  output logic        frame_tick
);

  localparam int CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
  localparam int HW       = $clog2(HOLD_EFF + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_EFF);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   msg_data_q, msg_data_d;
  logic [7:0]    msg_mask_q, msg_mask_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    cath_q, cath_d;
  logic          page_q, page_d;
  logic          msg_ready_q, msg_ready_d;

  logic          scan_tick;
  logic          accept;
  logic          blink_dark;
  logic          sel_lit;
  logic [3:0]    sel_nib;
  logic          sel_dp;
  logic [7:0]    dec_cath;

  assign scan_tick  = (cnt_q == SCAN_LAST);
  assign frame_tick = scan_tick && (digit_q == 3'(NUM_DIGITS - 1));
  assign accept     = (state_q == GAME) && msg_valid && msg_ready_q;

  assign cnt_d   = scan_tick ? '0 : cnt_q + CW'(1);
  assign digit_d = scan_tick ? digit_q + 3'd1 : digit_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    msg_data_d = msg_data_q;
    msg_mask_d = msg_mask_q;
    case (state_q)
      GAME: begin
        if (accept) begin
          state_d    = MSG;
          hold_d     = HOLD_INIT;
          msg_data_d = msg_data;
          msg_mask_d = msg_mask;
        end
      end
      MSG: begin
        // Cancel wins over a coincident final frame_tick; both land in GAME anyway.
        if (msg_cancel) begin
          state_d = GAME;
          hold_d  = '0;
        end else if (frame_tick) begin
          hold_d = hold_q - HW'(1);
          if (hold_q == HW'(1)) begin
            state_d = GAME;
          end
        end
      end
      default: state_d = GAME;
    endcase
    msg_ready_d = (state_d == GAME);
    page_d      = (state_d == MSG);
  end

`ifdef SSD_SCHED_BLINK_EN
  localparam int BLINK_EFF = (BLINK_FRAMES < 1) ? 1 : BLINK_FRAMES;
  localparam int BW        = (BLINK_EFF > 1) ? $clog2(BLINK_EFF) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_dark_q, blink_dark_d;

  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    blink_dark_d = blink_dark_q;
    if (accept) begin
      blink_cnt_d  = '0;
      blink_dark_d = 1'b0;
    end else if ((state_q == MSG) && frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_EFF - 1)) begin
        blink_cnt_d  = '0;
        blink_dark_d = ~blink_dark_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      blink_cnt_q  <= '0;
      blink_dark_q <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      blink_dark_q <= blink_dark_d;
    end
  end

  assign blink_dark = (state_q == MSG) && blink_dark_q;
`else
  assign blink_dark = 1'b0;
`endif

  // Page source follows state_q, so a page switch only shows at the next slot boundary.
  always_comb begin
    if (state_q == MSG) begin
      sel_lit = msg_mask_q[digit_q];
      sel_nib = msg_data_q[{digit_q, 2'b00} +: 4];
      sel_dp  = 1'b0;
    end else begin
      sel_lit = game_mask[digit_q];
      sel_nib = game_data[{digit_q, 2'b00} +: 4];
      sel_dp  = game_dp[digit_q];
    end
  end

  ssd_hex_decoder u_dec (
    .nibble_i   (sel_nib),
    .dp_i       (sel_dp),
    .cathodes_o (dec_cath)
  );

  always_comb begin
    an_d   = an_q;
    cath_d = cath_q;
    if (scan_tick) begin
      if (sel_lit && !blink_dark) begin
        an_d   = ~(8'h01 << digit_q);
        cath_d = dec_cath;
      end else begin
        an_d   = BLANK;
        cath_d = BLANK;
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q     <= GAME;
      cnt_q       <= '0;
      digit_q     <= '0;
      hold_q      <= '0;
      msg_data_q  <= '0;
      msg_mask_q  <= '0;
      an_q        <= BLANK;
      cath_q      <= BLANK;
      page_q      <= 1'b0;
      msg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      hold_q      <= hold_d;
      msg_data_q  <= msg_data_d;
      msg_mask_q  <= msg_mask_d;
      an_q        <= an_d;
      cath_q      <= cath_d;
      page_q      <= page_d;
      msg_ready_q <= msg_ready_d;
    end
  end

  assign An        = an_q;
  assign Cathodes  = cath_q;
  assign page      = page_q;
  assign msg_ready = msg_ready_q;

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// tb/tb_ssd_display_scheduler.sv - scoreboard bench for ssd_display_scheduler (SCAN_DIV=4, HOLD_FRAMES=3)
`timescale 1ns/1ps
module tb_ssd_display_scheduler;

  logic        ClkPort = 1'b0;
  logic        Reset   = 1'b1;
  logic [31:0] game_data;
  logic [7:0]  game_mask;
  logic [7:0]  game_dp;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_data;
  logic [7:0]  msg_mask;
  logic        msg_cancel;
  logic [7:0]  An;
  logic [7:0]  Cathodes;
  logic        page;
  logic        frame_tick;

  always #5 ClkPort = ~ClkPort;

  ssd_display_scheduler #(.SCAN_DIV(4), .HOLD_FRAMES(3)) dut (
    .ClkPort    (ClkPort),
    .Reset      (Reset),
    .game_data  (game_data),
    .game_mask  (game_mask),
    .game_dp    (game_dp),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .msg_mask   (msg_mask),
    .msg_cancel (msg_cancel),
    .An         (An),
    .Cathodes   (Cathodes),
    .page       (page),
    .frame_tick (frame_tick)
  );

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  bit mon_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  // Hand-computed {abcdefg, Dp=1} for digits 0..F.
  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  function automatic logic [15:0] exp_slot(input int d, input logic [31:0] data,
                                           input logic [7:0] mask, input logic [7:0] dp);
    logic [3:0] nib;
    logic [7:0] an;
    nib = data[d*4 +: 4];
    an  = 8'h01 << d;
    if (!mask[d]) return 16'hFFFF;
    return {~an, seg_tab[nib] & ~{7'b0, dp[d]}};
  endfunction

  task automatic push_slots(input logic [31:0] data, input logic [7:0] mask,
                            input logic [7:0] dp, input int first, input int last);
    for (int d = first; d <= last; d++) exp_q.push_back(exp_slot(d, data, mask, dp));
  endtask

  task automatic wait_ec(input int n);
    int guard = 0;
    while (ecount != n && guard < 5000) begin
      @(negedge ClkPort);
      guard++;
    end
    if (ecount != n) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got edge %0d expected %0d", ecount, n);
    end
  endtask

  // Monitor: one slot is loaded every 4 edges after reset release.
  always @(posedge ClkPort) begin
    if (Reset) begin
      ecount = 0;
    end else begin
      ecount = ecount + 1;
      if (mon_en && (ecount % 4 == 0)) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slot_underflow: got An=%h Cathodes=%h expected no slot (edge %0d)",
                   An, Cathodes, ecount);
        end else begin
          mon_e = exp_q.pop_front();
          check8("slot_an", An, mon_e[15:8]);
          check8("slot_cath", Cathodes, mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    game_data  = 32'h76543210;
    game_mask  = 8'hFF;
    game_dp    = 8'h00;
    msg_valid  = 1'b0;
    msg_data   = 32'h0;
    msg_mask   = 8'h00;
    msg_cancel = 1'b0;
    Reset      = 1'b1;
    repeat (5) @(posedge ClkPort);
    @(negedge ClkPort);
    check8("reset_an", An, 8'hFF);
    check8("reset_cath", Cathodes, 8'hFF);
    check8("reset_ready", msg_ready, 8'h0);
    check8("reset_page", page, 8'h0);
    check8("reset_frame_tick", frame_tick, 8'h0);

    push_slots(32'h76543210, 8'hFF, 8'h00, 0, 7);
    push_slots(32'h76543210, 8'hFF, 8'h02, 0, 7);
    mon_en = 1'b1;
    Reset  = 1'b0;

    wait_ec(1);
    check8("ready_after_release", msg_ready, 8'h1);
    check8("page_after_release", page, 8'h0);
    wait_ec(3);
    check8("an_before_first_tick", An, 8'hFF);
    check8("cath_before_first_tick", Cathodes, 8'hFF);
    wait_ec(30);
    check8("frame_tick_idle", frame_tick, 8'h0);
    wait_ec(31);
    check8("frame_tick_pulse", frame_tick, 8'h1);
    wait_ec(32);
    check8("frame_tick_after", frame_tick, 8'h0);
    game_dp = 8'h02;

    wait_ec(64);
    game_dp   = 8'h00;
    check8("ready_before_msg", msg_ready, 8'h1);
    msg_valid = 1'b1;
    msg_data  = 32'hDEADBEEF;
    msg_mask  = 8'hFF;
    for (int f = 0; f < 3; f++) push_slots(32'hDEADBEEF, 8'hFF, 8'h00, 0, 7);
    wait_ec(65);
    check8("ready_in_msg", msg_ready, 8'h0);
    check8("page_in_msg", page, 8'h1);
    msg_valid = 1'b0;
    msg_data  = 32'h0;
    msg_mask  = 8'h00;

    wait_ec(100);
    msg_valid = 1'b1;
    msg_data  = 32'h11111111;
    wait_ec(101);
    check8("valid_ignored_in_msg", msg_ready, 8'h0);
    msg_valid = 1'b0;

    wait_ec(159);
    check8("page_last_msg_frame", page, 8'h1);
    wait_ec(160);
    check8("page_after_hold", page, 8'h0);
    check8("ready_after_hold", msg_ready, 8'h1);
    push_slots(32'h76543210, 8'hFF, 8'h00, 0, 7);

    wait_ec(192);
    msg_valid = 1'b1;
    msg_data  = 32'h1234CDEF;
    msg_mask  = 8'h0F;
    push_slots(32'h1234CDEF, 8'h0F, 8'h00, 0, 7);
    push_slots(32'h1234CDEF, 8'h0F, 8'h00, 0, 1);
    push_slots(32'h76543210, 8'hFF, 8'h00, 2, 7);
    wait_ec(193);
    msg_valid = 1'b0;
    check8("page_msg2", page, 8'h1);
    wait_ec(233);
    msg_cancel = 1'b1;
    wait_ec(234);
    msg_cancel = 1'b0;
    check8("page_after_cancel", page, 8'h0);
    check8("ready_after_cancel", msg_ready, 8'h1);

    wait_ec(256);
    game_data = 32'hA5C39E71;
    game_mask = 8'h0F;
    game_dp   = 8'h81;
    push_slots(32'hA5C39E71, 8'h0F, 8'h81, 0, 7);

    wait_ec(288);
    msg_valid = 1'b1;
    msg_data  = 32'hDEADBEEF;
    msg_mask  = 8'hFF;
    push_slots(32'hDEADBEEF, 8'hFF, 8'h00, 0, 1);
    wait_ec(289);
    msg_valid = 1'b0;
    check8("page_msg3", page, 8'h1);

    wait_ec(297);
    Reset = 1'b1;
    #1;
    check8("midmsg_reset_an", An, 8'hFF);
    check8("midmsg_reset_cath", Cathodes, 8'hFF);
    check8("midmsg_reset_page", page, 8'h0);
    check8("midmsg_reset_ready", msg_ready, 8'h0);
    repeat (3) @(negedge ClkPort);
    push_slots(32'hA5C39E71, 8'h0F, 8'h81, 0, 7);
    Reset = 1'b0;
    wait_ec(1);
    check8("page_after_rerelease", page, 8'h0);
    check8("ready_after_rerelease", msg_ready, 8'h1);
    wait_ec(32);
    check8("scoreboard_drained", 8'(exp_q.size()), 8'h0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
